// File: rtl/lbist_sig_check.sv
// LBIST signature checker: sequences the MISR window, captures and compares.
// Optional debug ports (sig_dbg, seg_mismatch) under LBIST_SIG_DEBUG_EN.
module lbist_sig_check #(
  parameter int unsigned  N                  = 240,
  parameter int unsigned  N_PATTERNS         = 1024,
  parameter logic [N-1:0] EXPECTED_SIGNATURE = '0,
  parameter int unsigned  SETTLE_CYCLES      = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] misr_dout,
  output logic         misr_en,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic         fail
`ifdef LBIST_SIG_DEBUG_EN
  ,
  output logic [N-1:0]    sig_dbg,
  output logic [N/24-1:0] seg_mismatch
`endif
);

  localparam int unsigned CW =
    (N_PATTERNS > 1) ? $clog2(N_PATTERNS) : 1;
  localparam int unsigned NSEG = N / 24;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    SETTLE,
    CAPTURE,
    COMPARE,
    DONE
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  pcnt_q, pcnt_d;
  logic [3:0]     scnt_q, scnt_d;
  logic [N-1:0]   sig_q, sig_d;
  logic           misr_en_q, misr_en_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           pass_q, pass_d;
  logic           fail_q, fail_d;
  logic [NSEG-1:0] seg_eq;
  logic           sig_eq;
  logic           accept;

  // Wide compare split into 24-bit slices to keep the reduction shallow
  for (genvar g = 0; g < NSEG; g++) begin : g_seg
    assign seg_eq[g] =
      sig_q[24*g +: 24] == EXPECTED_SIGNATURE[24*g +: 24];
  end

  assign sig_eq = &seg_eq;
  assign accept = start &&
    ((state_q == IDLE) || (state_q == DONE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pcnt_q    <= '0;
      scnt_q    <= '0;
      sig_q     <= '0;
      misr_en_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pcnt_q    <= pcnt_d;
      scnt_q    <= scnt_d;
      sig_q     <= sig_d;
      misr_en_q <= misr_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    scnt_d  = scnt_q;
    sig_d   = sig_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          state_d = RUN;
          pcnt_d  = CW'(N_PATTERNS - 1);
          sig_d   = '0;
        end
      end
      RUN: begin
        if (pcnt_q == '0) begin
          state_d = SETTLE;
          scnt_d  = 4'(SETTLE_CYCLES - 1);
        end else begin
          pcnt_d = pcnt_q - 1'b1;
        end
      end
      SETTLE: begin
        if (scnt_q == '0) begin
          state_d = CAPTURE;
        end else begin
          scnt_d = scnt_q - 1'b1;
        end
      end
      CAPTURE: begin
        sig_d   = misr_dout;
        state_d = COMPARE;
      end
      COMPARE: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they land in flops
  always_comb begin
    misr_en_d = (state_d == RUN);
    busy_d    = (state_d == RUN) || (state_d == SETTLE) ||
                (state_d == CAPTURE) || (state_d == COMPARE);
    done_d    = (state_d == DONE);
    pass_d    = 1'b0;
    if (state_q == COMPARE) begin
      pass_d = sig_eq;
    end else if (state_d == DONE) begin
      pass_d = pass_q;
    end
    fail_d = done_d && !pass_d;
  end

  assign misr_en = misr_en_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign pass    = pass_q;
  assign fail    = fail_q;

`ifdef LBIST_SIG_DEBUG_EN
  logic [NSEG-1:0] segm_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      segm_q <= '0;
    end else if (accept) begin
      segm_q <= '0;
    end else if (state_q == COMPARE) begin
      segm_q <= ~seg_eq;
    end
  end

  assign sig_dbg      = sig_q;
  assign seg_mismatch = segm_q;
`endif

endmodule
